robot_walker: RTL and testbench

Parametrised wall-following robot core for the pipe-cleaning world. It holds the robot's position and orientation on a ROWS×COLS map and paces moves with an internal step divider. Once per step it samples the wall sensors and decides among three actions: move, turn toward the followed wall, or turn away. It instantiates below the world top level, which feeds sensors and renders `row`/`column`/`dir` on VGA. It generalises the fixed 10×20 left-hand robot: map size, step rate, start pose and follow side (left/right) are all configurable, and it adds stuck detection.

---
 rtl/robot_pkg.sv | 59 +++++
 rtl/robot_walker_step_timer.sv | 45 ++++
 rtl/robot_walker.sv | 171 +++++++++++++++++
 tb/tb_robot_walker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// +--------------------------------------------------------------------------+
// | robot_pkg: orientation/action encodings and turn helpers for the walker. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package robot_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'b00,
        DIR_S = 2'b01,
        DIR_E = 2'b10,
        DIR_W = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ACT_MOVE = 2'b00,
        ACT_SIDE = 2'b01,
        ACT_AWAY = 2'b10
    } act_e;

    localparam logic [2:0] STUCK_TURNS = 3'd4;

    function automatic dir_e left_of(input dir_e d);
        case (d)
            DIR_N:   return DIR_W;
            DIR_E:   return DIR_N;
            DIR_S:   return DIR_E;
            default: return DIR_S;
        endcase
    endfunction

    function automatic dir_e right_of(input dir_e d);
        case (d)
            DIR_N:   return DIR_E;
            DIR_E:   return DIR_S;
            DIR_S:   return DIR_W;
            default: return DIR_N;
        endcase
    endfunction

    // Turning away rotates opposite to the followed side.
    function automatic dir_e opposite_turn(input dir_e d, input logic follow_right);
        return follow_right ? left_of(d) : right_of(d);
    endfunction

    function automatic logic off_map(input dir_e d, input logic at_n, input logic at_s,
                                     input logic at_e, input logic at_w);
        case (d)
            DIR_N:   return at_n;
            DIR_S:   return at_s;
            DIR_E:   return at_e;
            default: return at_w;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/robot_walker_step_timer.sv
// +--------------------------------------------------------------------------+
// | step_timer: free-running 0..STEP_DIV-1 divider, tick on the last count.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module step_timer #(
    parameter int STEP_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!enable) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable && (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/robot_walker.sv
// +--------------------------------------------------------------------------+
// | robot_walker: wall-following robot pose register with stuck detection.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module robot_walker
    import robot_pkg::*;
#(
    parameter int          ROWS      = 10,
    parameter int          COLS      = 20,
    parameter int          STEP_DIV  = 2,
    parameter int          START_ROW = 1,
    parameter int          START_COL = 1,
    parameter logic [1:0]  START_DIR = 2'b00,
    localparam int         RW        = $clog2(ROWS + 1),
    localparam int         CW        = $clog2(COLS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          mode,
    input  logic          wall_ahead,
    input  logic          wall_side,
    output logic [RW-1:0] row,
    output logic [CW-1:0] column,
    output logic [1:0]    dir,
    output logic          step,
    output logic [1:0]    action,
    output logic          stuck
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_STUCK = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    dir_e          dir_q, dir_d;
    act_e          act_q, act_d;
    logic          step_q, step_d;
    logic          latch_q, latch_d;
    logic [2:0]    turns_q, turns_d;

    logic tick;
    logic timer_en;
    logic at_n, at_s, at_e, at_w;
    dir_e side_dir, away_dir;
    logic eff_ahead, eff_side;
    logic do_move, do_side, do_away;

    assign timer_en = run && (state_q != ST_STUCK);

    step_timer #(
        .STEP_DIV(STEP_DIV)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .enable(timer_en),
        .tick  (tick)
    );

    assign at_n      = (row_q == RW'(1));
    assign at_s      = (row_q == RW'(ROWS));
    assign at_e      = (col_q == CW'(COLS));
    assign at_w      = (col_q == CW'(1));
    assign side_dir  = mode ? right_of(dir_q) : left_of(dir_q);
    assign away_dir  = opposite_turn(dir_q, mode);
    assign eff_ahead = wall_ahead || off_map(dir_q, at_n, at_s, at_e, at_w);
    assign eff_side  = wall_side || off_map(side_dir, at_n, at_s, at_e, at_w);

    // A pending side-turn forces a forward attempt so the robot cannot spin in place.
    always_comb begin
        do_move = 1'b0;
        do_side = 1'b0;
        do_away = 1'b0;
        if (latch_q) begin
            do_move = !eff_ahead;
            do_away = eff_ahead;
        end else if (!eff_side) begin
            do_side = 1'b1;
        end else if (!eff_ahead) begin
            do_move = 1'b1;
        end else begin
            do_away = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            row_q   <= RW'(START_ROW);
            col_q   <= CW'(START_COL);
            dir_q   <= dir_e'(START_DIR);
            act_q   <= ACT_MOVE;
            step_q  <= 1'b0;
            latch_q <= 1'b0;
            turns_q <= 3'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dir_q   <= dir_d;
            act_q   <= act_d;
            step_q  <= step_d;
            latch_q <= latch_d;
            turns_q <= turns_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_STUCK) begin
            state_d = ST_STUCK;
        end else if (tick && !do_move && (turns_q == STUCK_TURNS - 3'd1)) begin
            state_d = ST_STUCK;
        end else begin
            state_d = ST_COUNT;
        end
    end

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        dir_d   = dir_q;
        act_d   = act_q;
        step_d  = 1'b0;
        latch_d = latch_q;
        turns_d = turns_q;
        if (!run) begin
            latch_d = 1'b0;
            turns_d = 3'd0;
        end else if (tick) begin
            step_d = 1'b1;
            if (do_move) begin
                act_d   = ACT_MOVE;
                latch_d = 1'b0;
                turns_d = 3'd0;
                case (dir_q)
                    DIR_N:   row_d = row_q - RW'(1);
                    DIR_S:   row_d = row_q + RW'(1);
                    DIR_E:   col_d = col_q + CW'(1);
                    default: col_d = col_q - CW'(1);
                endcase
            end else if (do_side) begin
                act_d   = ACT_SIDE;
                dir_d   = side_dir;
                latch_d = 1'b1;
                turns_d = turns_q + 3'd1;
            end else if (do_away) begin
                act_d   = ACT_AWAY;
                dir_d   = away_dir;
                latch_d = 1'b0;
                turns_d = turns_q + 3'd1;
            end
        end
    end

    assign row    = row_q;
    assign column = col_q;
    assign dir    = dir_q;
    assign step   = step_q;
    assign action = act_q;
    assign stuck  = (state_q == ST_STUCK);

endmodule

`default_nettype wire

// File: tb/tb_robot_walker.sv
// +--------------------------------------------------------------------------+
// | tb_robot_walker: directed + random scoreboard bench for robot_walker.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_robot_walker;

    localparam int DIV1 = 2;
    localparam int DIV2 = 3;

    typedef struct {
        int row;
        int col;
        int dir;
        int act;
        int turns;
        bit latch;
        bit stuck;
    } pose_t;

    logic       clock;
    logic       reset;
    logic       run1, mode1, wa1, ws1;
    logic [3:0] row1;
    logic [4:0] col1;
    logic [1:0] dir1, action1;
    logic       step1, stuck1;
    logic       run2, mode2, wa2, ws2;
    logic [2:0] row2, col2;
    logic [1:0] dir2, action2;
    logic       step2, stuck2;

    int    errors = 0;
    int    checks = 0;
    pose_t m1, m2;
    pose_t sb1[$];
    pose_t sb2[$];

    robot_walker #(.STEP_DIV(DIV1)) dut1 (
        .clock(clock), .reset(reset), .run(run1), .mode(mode1),
        .wall_ahead(wa1), .wall_side(ws1),
        .row(row1), .column(col1), .dir(dir1), .step(step1),
        .action(action1), .stuck(stuck1)
    );

    robot_walker #(
        .ROWS(4), .COLS(6), .STEP_DIV(DIV2),
        .START_ROW(2), .START_COL(3), .START_DIR(2'b10)
    ) dut2 (
        .clock(clock), .reset(reset), .run(run2), .mode(mode2),
        .wall_ahead(wa2), .wall_side(ws2),
        .row(row2), .column(col2), .dir(dir2), .step(step2),
        .action(action2), .stuck(stuck2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent reference: 0=N 1=S 2=E 3=W
    function automatic int lft(input int d);
        case (d)
            0: return 3;
            1: return 2;
            2: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int rgt(input int d);
        case (d)
            0: return 2;
            1: return 3;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit off(input int d, input int r, input int c, input int rows, input int cols);
        return (d == 0 && r == 1) || (d == 1 && r == rows) || (d == 2 && c == cols) || (d == 3 && c == 1);
    endfunction

    function automatic pose_t model_next(input pose_t p, input bit md, input bit wa, input bit ws,
                                         input int rows, input int cols);
        pose_t n = p;
        int    sd = md ? rgt(p.dir) : lft(p.dir);
        int    aw = md ? lft(p.dir) : rgt(p.dir);
        bit    ea = wa || off(p.dir, p.row, p.col, rows, cols);
        bit    es = ws || off(sd, p.row, p.col, rows, cols);
        bit    mv = 0;
        if (p.latch) begin
            n.latch = 0;
            if (!ea) mv = 1;
            else begin n.dir = aw; n.act = 2; end
        end else if (!es) begin
            n.dir = sd; n.act = 1; n.latch = 1;
        end else if (!ea) begin
            mv = 1;
        end else begin
            n.dir = aw; n.act = 2;
        end
        if (mv) begin
            n.act = 0;
            n.turns = 0;
            case (p.dir)
                0: n.row = p.row - 1;
                1: n.row = p.row + 1;
                2: n.col = p.col + 1;
                default: n.col = p.col - 1;
            endcase
        end else begin
            n.turns = p.turns + 1;
            if (n.turns == 4) n.stuck = 1;
        end
        return n;
    endfunction

    task automatic wait1();
        int    n = 0;
        pose_t e;
        while (n < 20) begin
            @(negedge clock);
            n++;
            if (step1) break;
        end
        e = sb1.pop_front();
        check("dut1_step_seen", step1, 1);
        check("dut1_step_spacing", n, DIV1);
        check("dut1_row", row1, e.row);
        check("dut1_col", col1, e.col);
        check("dut1_dir", dir1, e.dir);
        check("dut1_action", action1, e.act);
        check("dut1_stuck", stuck1, e.stuck);
    endtask

    task automatic act1(input bit md, input bit wa, input bit ws);
        pose_t e;
        mode1 = md; wa1 = wa; ws1 = ws;
        e = model_next(m1, md, wa, ws, 10, 20);
        sb1.push_back(e);
        m1 = e;
        wait1();
    endtask

    task automatic wait2();
        int    n = 0;
        pose_t e;
        while (n < 20) begin
            @(negedge clock);
            n++;
            if (step2) break;
        end
        e = sb2.pop_front();
        check("rand_step_seen", step2, 1);
        check("rand_step_spacing", n, DIV2);
        check("rand_row_range", (row2 >= 1 && row2 <= 4), 1);
        check("rand_col_range", (col2 >= 1 && col2 <= 6), 1);
        check("rand_row", row2, e.row);
        check("rand_col", col2, e.col);
        check("rand_dir", dir2, e.dir);
        check("rand_action", action2, e.act);
        check("rand_stuck", stuck2, e.stuck);
    endtask

    task automatic act2(input bit md, input bit wa, input bit ws);
        pose_t e;
        mode2 = md; wa2 = wa; ws2 = ws;
        e = model_next(m2, md, wa, ws, 4, 6);
        sb2.push_back(e);
        m2 = e;
        wait2();
    endtask

    initial begin
        int steps_seen;
        reset = 1'b0;
        run1 = 0; mode1 = 0; wa1 = 0; ws1 = 0;
        run2 = 0; mode2 = 0; wa2 = 0; ws2 = 0;
        m1 = '{row: 1, col: 1, dir: 0, act: 0, turns: 0, latch: 0, stuck: 0};
        m2 = '{row: 2, col: 3, dir: 2, act: 0, turns: 0, latch: 0, stuck: 0};

        repeat (2) @(negedge clock);
        check("reset_row", row1, 1);
        check("reset_col", col1, 1);
        check("reset_dir", dir1, 0);
        check("reset_step", step1, 0);
        check("reset_action", action1, 0);
        check("reset_stuck", stuck1, 0);
        check("reset_row2", row2, 2);
        check("reset_col2", col2, 3);
        check("reset_dir2", dir2, 2);
        reset = 1'b1;
        @(negedge clock);

        // Free map from (1,1) north, left-hand: turn away to east, then walk the top row
        run1 = 1;
        act1(0, 0, 0);
        check("first_turn_east", dir1, 2);
        check("first_turn_action", action1, 2);
        act1(0, 0, 0);
        check("first_move_col", col1, 2);
        for (int i = 0; i < 18; i++) act1(0, 0, 0);
        check("east_edge_col", col1, 20);

        // East edge in right-hand mode: side turn south, then move down
        act1(1, 0, 0);
        check("edge_side_turn", action1, 1);
        check("edge_side_dir", dir1, 1);
        act1(1, 0, 0);
        check("edge_move_row", row1, 2);

        // Latch: side turn, blocked ahead gives turn-away, next free side turns again
        act1(1, 0, 0);
        act1(1, 1, 0);
        check("latch_turn_away", action1, 2);
        act1(1, 1, 0);
        check("latch_cleared_side", action1, 1);
        act1(1, 0, 0);
        check("latch_move_col", col1, 19);

        // Asynchronous reset in the middle of a count
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async_row", row1, 1);
        check("async_col", col1, 1);
        check("async_dir", dir1, 0);
        check("async_step", step1, 0);
        check("async_action", action1, 0);
        check("async_stuck", stuck1, 0);
        @(negedge clock);
        reset = 1'b1;
        m1 = '{row: 1, col: 1, dir: 0, act: 0, turns: 0, latch: 0, stuck: 0};

        // Boxed in: four turn-aways return to north and raise stuck
        for (int i = 0; i < 4; i++) act1(0, 1, 1);
        check("stuck_dir_back", dir1, 0);
        check("stuck_raised", stuck1, 1);
        steps_seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (step1) steps_seen++;
        end
        check("stuck_no_steps", steps_seen, 0);
        run1 = 0;
        @(negedge clock);
        check("run_low_clears_stuck", stuck1, 0);
        check("run_low_keeps_row", row1, 1);
        run1 = 1;
        m1.turns = 0; m1.latch = 0; m1.stuck = 0;
        act1(0, 0, 0);
        check("restart_turn_east", dir1, 2);
        run1 = 0;

        // Random sensors on a 4x6 map
        run2 = 1;
        for (int i = 0; i < 1000; i++) begin
            act2(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 35), 1'($urandom_range(0, 1)));
            if (m2.stuck) begin
                run2 = 0;
                @(negedge clock);
                check("rand_stuck_clear", stuck2, 0);
                run2 = 1;
                m2.turns = 0; m2.latch = 0; m2.stuck = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
